// File: rtl/rcservo_sequencer.sv
// Frame-based sequencer that time-shares one pulse down-counter and one position adder
// among NUM_CH RC-servo channels, emitting non-overlapping pulses in fixed slots.
module rcservo_sequencer #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned FRAME_CYCLES  = 960000,
  parameter int unsigned SLOT_CYCLES   = 120000,
  parameter int unsigned CENTER_CYCLES = 72000,
  parameter int unsigned RANGE_CYCLES  = 24000,
  parameter int unsigned SHIFT         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NUM_CH*32-1:0] jointFreqCmd,
  output logic [NUM_CH*32-1:0] jointFeedback,
  output logic [NUM_CH-1:0]    PWM,
  output logic                 frame_sync,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(FRAME_CYCLES);
  localparam int unsigned WidW = $clog2(CENTER_CYCLES + RANGE_CYCLES + 1);
  localparam logic [CntW-1:0] FrameLast = CntW'(FRAME_CYCLES - 1);
  localparam logic [CntW-1:0] UpdLast   = CntW'(NUM_CH - 1);
  localparam logic [CntW-1:0] SlotLast  = CntW'(NUM_CH + (NUM_CH - 1) * SLOT_CYCLES);
  localparam logic signed [32:0] RangeHi = $signed(33'(RANGE_CYCLES));
  localparam logic signed [32:0] RangeLo = -RangeHi;

  if (NUM_CH < 1 || NUM_CH + NUM_CH * SLOT_CYCLES > FRAME_CYCLES ||
      CENTER_CYCLES + RANGE_CYCLES >= SLOT_CYCLES || CENTER_CYCLES <= RANGE_CYCLES) begin : g_bad
    $error("rcservo_sequencer: illegal frame/slot/pulse parameters");
  end

  typedef enum logic [1:0] {StIdle, StUpdate, StSlot, StWait} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    frame_cnt_q, frame_cnt_d;
  logic               stop_q, stop_d;
  logic [NUM_CH-1:0]  pwm_q, pwm_d;
  logic [WidW-1:0]    pulse_cnt_q, pulse_cnt_d;
  logic signed [31:0] pos_q [NUM_CH];
  logic signed [31:0] pos_d [NUM_CH];

  logic               running, run;
  logic signed [31:0] upd_pos, upd_cmd, inc, upd_new;
  logic signed [32:0] sum;
  logic               slot_hit;
  logic signed [31:0] slot_pos, width;
  logic [NUM_CH-1:0]  slot_oh;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    stop_d      = stop_q;
    pwm_d       = pwm_q;
    pulse_cnt_d = pulse_cnt_q;
    pos_d       = pos_q;
    upd_pos     = '0;
    upd_cmd     = '0;
    slot_hit    = 1'b0;
    slot_pos    = '0;
    slot_oh     = '0;

    // Operand muxes in front of the single shared adder and the single pulse counter.
    for (int k = 0; k < NUM_CH; k++) begin
      if (frame_cnt_q == CntW'(k)) begin
        upd_pos = pos_q[k];
        upd_cmd = jointFreqCmd[32*k +: 32];
      end
      if (frame_cnt_q == CntW'(NUM_CH + k * SLOT_CYCLES)) begin
        slot_hit = 1'b1;
        slot_pos = pos_q[k];
        slot_oh  = NUM_CH'(1) << k;
      end
    end

    inc = upd_cmd >>> SHIFT;
    sum = {upd_pos[31], upd_pos} + {inc[31], inc};
    if (sum > RangeHi) begin
      upd_new = RangeHi[31:0];
    end else if (sum < RangeLo) begin
      upd_new = RangeLo[31:0];
    end else begin
      upd_new = sum[31:0];
    end
    width = $signed(32'(CENTER_CYCLES)) + slot_pos;

    running = (state_q != StIdle);
    run     = enable && !stop_q;

    if (pwm_q != '0) begin
      if (pulse_cnt_q == '0) begin
        pwm_d = '0;
      end else begin
        pulse_cnt_d = pulse_cnt_q - WidW'(1);
      end
    end

    if (running) begin
      frame_cnt_d = (frame_cnt_q == FrameLast) ? '0 : frame_cnt_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        frame_cnt_d = '0;
        stop_d      = 1'b0;
        if (enable) state_d = StUpdate;
      end
      StUpdate: begin
        if (run) begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (frame_cnt_q == CntW'(k)) pos_d[k] = upd_new;
          end
        end
        if (frame_cnt_q == UpdLast) state_d = StSlot;
      end
      StSlot: begin
        if (run && slot_hit) begin
          pwm_d       = slot_oh;
          pulse_cnt_d = WidW'(width - 32'sd1);
        end
        if (frame_cnt_q == SlotLast) state_d = StWait;
      end
      StWait: begin
        if (frame_cnt_q == FrameLast) state_d = enable ? StUpdate : StIdle;
      end
    endcase

    // Once enable drops the frame is abandoned, even if enable returns before the
    // running pulse finishes; the next frame then restarts cleanly from count 0.
    if (running && !enable) stop_d = 1'b1;
    if (running && (!enable || stop_q) && pwm_q == '0) begin
      state_d     = StIdle;
      frame_cnt_d = '0;
      stop_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      frame_cnt_q <= '0;
      stop_q      <= 1'b0;
      pwm_q       <= '0;
      pulse_cnt_q <= '0;
      for (int k = 0; k < NUM_CH; k++) pos_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      stop_q      <= stop_d;
      pwm_q       <= pwm_d;
      pulse_cnt_q <= pulse_cnt_d;
      for (int k = 0; k < NUM_CH; k++) pos_q[k] <= pos_d[k];
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_fb
    assign jointFeedback[32*k +: 32] = pos_q[k];
  end

  assign PWM        = pwm_q;
  assign busy       = (state_q != StIdle);
  assign frame_sync = (state_q == StUpdate) && (frame_cnt_q == '0);

endmodule

// File: tb/tb_rcservo_sequencer.sv
// Directed bench for rcservo_sequencer: per-frame vector table plus hand-written
// disable-mid-pulse and reset-mid-pulse sequences.
module tb_rcservo_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [63:0] cmd;
  logic [63:0] fb;
  logic [1:0]  pwm;
  logic        frame_sync;
  logic        busy;

  int n_vec  = 0;
  int n_fail = 0;

  rcservo_sequencer #(
    .NUM_CH       (2),
    .FRAME_CYCLES (1000),
    .SLOT_CYCLES  (200),
    .CENTER_CYCLES(100),
    .RANGE_CYCLES (50),
    .SHIFT        (0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .jointFreqCmd (cmd),
    .jointFeedback(fb),
    .PWM          (pwm),
    .frame_sync   (frame_sync),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cmd0;
    logic [31:0] cmd1;
    int          fb0;
    int          fb1;
    int          w0;
    int          w1;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int fb_of(input int ch);
    logic [31:0] w;
    w = fb[32*ch +: 32];
    return int'($signed(w));
  endfunction

  task automatic wait_sync(output int waited);
    waited = -1;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (frame_sync) begin
        waited = n;
        break;
      end
    end
  endtask

  // Waits for a frame_sync, then samples cycles 1..999 of that frame.
  task automatic measure(output int waited, output int r0, output int w0, output int r1,
                         output int w1, output int f0, output int f1, output int xs,
                         output int ov, output int bz);
    r0 = -1; r1 = -1; w0 = 0; w1 = 0; f0 = 0; f1 = 0; xs = 0; ov = 0; bz = 0;
    wait_sync(waited);
    if (waited < 0) return;
    for (int c = 1; c < 1000; c++) begin
      @(negedge clk);
      if (frame_sync) xs++;
      if (pwm[0]) begin
        if (r0 < 0) r0 = c;
        w0++;
      end
      if (pwm[1]) begin
        if (r1 < 0) r1 = c;
        w1++;
      end
      if (pwm == 2'b11) ov++;
      if (c == 5) begin
        f0 = fb_of(0);
        f1 = fb_of(1);
        bz = int'(busy);
      end
    end
  endtask

  task automatic check_frame(input string tag, input int exp_w0, input int exp_w1,
                             input int exp_f0, input int exp_f1);
    int waited, r0, w0, r1, w1, f0, f1, xs, ov, bz;
    measure(waited, r0, w0, r1, w1, f0, f1, xs, ov, bz);
    check({tag, " sync period"}, waited, 1);
    check({tag, " extra sync"}, xs, 0);
    check({tag, " overlap"}, ov, 0);
    check({tag, " busy"}, bz, 1);
    check({tag, " rise0"}, r0, 3);
    check({tag, " rise1"}, r1, 203);
    check({tag, " width0"}, w0, exp_w0);
    check({tag, " width1"}, w1, exp_w1);
    check({tag, " fb0"}, f0, exp_f0);
    check({tag, " fb1"}, f1, exp_f1);
  endtask

  initial begin
    int waited, hi0, hi1;

    vecs[0]  = '{32'd0,          32'd0,          0,   0,   100, 100};
    vecs[1]  = '{32'd10,         32'd0,          10,  0,   110, 100};
    vecs[2]  = '{32'd10,         32'd0,          20,  0,   120, 100};
    vecs[3]  = '{32'd10,         32'd0,          30,  0,   130, 100};
    vecs[4]  = '{32'd10,         32'd0,          40,  0,   140, 100};
    vecs[5]  = '{32'd10,         32'd0,          50,  0,   150, 100};
    vecs[6]  = '{32'd10,         32'd0,          50,  0,   150, 100};
    vecs[7]  = '{32'd0,          32'hFFFF_FF80,  50,  -50, 150, 50};
    vecs[8]  = '{32'h7FFF_FFFF,  32'd0,          50,  -50, 150, 50};
    vecs[9]  = '{32'h8000_0000,  32'd0,          -50, -50, 50,  50};
    vecs[10] = '{32'd0,          32'd30,         -50, -20, 50,  80};
    vecs[11] = '{32'd50,         32'd20,         0,   0,   100, 100};

    rst_n  = 1'b0;
    enable = 1'b0;
    cmd    = '0;
    repeat (3) @(negedge clk);
    check("reset pwm", int'(pwm), 0);
    check("reset frame_sync", int'(frame_sync), 0);
    check("reset busy", int'(busy), 0);
    check("reset fb0", fb_of(0), 0);
    check("reset fb1", fb_of(1), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle busy", int'(busy), 0);

    cmd    = {vecs[0].cmd1, vecs[0].cmd0};
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cmd = {vecs[i].cmd1, vecs[i].cmd0};
      check_frame($sformatf("v%0d", i), vecs[i].w0, vecs[i].w1, vecs[i].fb0, vecs[i].fb1);
    end

    // Disable 40 cycles into the PWM[0] pulse: pulse completes, PWM[1] never rises.
    cmd = '0;
    wait_sync(waited);
    check("dis sync period", waited, 1);
    hi0 = 0;
    hi1 = 0;
    for (int c = 1; c <= 43; c++) begin
      @(negedge clk);
      if (pwm[0]) hi0++;
    end
    check("dis pulse active", int'(pwm), 1);
    enable = 1'b0;
    for (int c = 44; c < 400; c++) begin
      @(negedge clk);
      if (pwm[0]) hi0++;
      if (pwm[1]) hi1++;
    end
    check("dis width0", hi0, 100);
    check("dis pwm1 highs", hi1, 0);
    check("dis busy", int'(busy), 0);
    check("dis fb0", fb_of(0), 0);
    check("dis fb1", fb_of(1), 0);
    enable = 1'b1;
    check_frame("reen", 100, 100, 0, 0);

    // Reset during the PWM[1] pulse.
    cmd = {32'd0, 32'd10};
    check_frame("pre", 110, 100, 10, 0);
    cmd = '0;
    wait_sync(waited);
    check("rst sync period", waited, 1);
    repeat (250) @(negedge clk);
    check("rst pwm1 active", int'(pwm), 2);
    rst_n = 1'b0;
    #1;
    check("rst pwm", int'(pwm), 0);
    check("rst fb0", fb_of(0), 0);
    check("rst busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_frame("post", 100, 100, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
